kogge_stone_pipe_adder: RTL and testbench

Parametrised, pipelined Kogge-Stone prefix adder/subtractor with valid/ready handshakes on input and output. It generalises the 4-bit combinational Kogge-Stone adder to any power-of-two width. Prefix levels are optionally registered, and it adds subtract mode and signed-overflow reporting. It sits in datapaths that need a high-fmax adder with back-pressure, such as accumulators and address generators.

---
 rtl/kogge_stone_pipe_adder.sv | 155 +++++++++++++++
 tb/tb_kogge_stone_pipe_adder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kogge_stone_pipe_adder.sv
// Kogge-Stone prefix adder/subtractor with optional register per prefix level
// and a single global valid/ready advance enable shared by every stage.
module kogge_stone_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned LEVELS = $clog2(WIDTH);

  // One prefix-level step on the group generate vector
  function automatic logic [WIDTH-1:0] g_step(input logic [WIDTH-1:0] g,
                                               input logic [WIDTH-1:0] p,
                                               input int unsigned      span);
    return g | (p & (g << span));
  endfunction

  // One prefix-level step on the group propagate vector; low span bits pass through
  function automatic logic [WIDTH-1:0] p_step(input logic [WIDTH-1:0] p,
                                               input int unsigned      span);
    return p & ((p << span) | ~({WIDTH{1'b1}} << span));
  endfunction

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] g0;
  logic [WIDTH-1:0] p0;
  logic             c0;

  // Operand conditioning and bitwise generate/propagate; carry-in folded into bit 0
  always_comb begin
    b_eff = sub ? ~b : b;
    c0    = sub | cin;
    p0    = a ^ b_eff;
    g0    = a & b_eff;
    g0[0] = g0[0] | (p0[0] & c0);
  end

  // Signals presented to the final sum stage
  logic [WIDTH-1:0] gf;
  logic [WIDTH-1:0] pf;
  logic             cf;
  logic             saf;
  logic             sbf;
  logic             vf;

  if (PIPE != 0) begin : g_pipe
    logic [WIDTH-1:0]  g_r  [LEVELS];
    logic [WIDTH-1:0]  pp_r [LEVELS-1];
    logic [WIDTH-1:0]  p_r  [LEVELS];
    logic [LEVELS-1:0] c_r;
    logic [LEVELS-1:0] sa_r;
    logic [LEVELS-1:0] sb_r;
    logic [LEVELS-1:0] v_r;

    // Stage valid bits shift with the global advance; bubbles travel as v=0
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_r <= '0;
      end else if (en) begin
        v_r <= {v_r[LEVELS-2:0], in_valid};
      end
    end

    // Prefix-level data registers; the last level's group propagate is never consumed
    always_ff @(posedge clk) begin
      if (en) begin
        g_r[0]  <= g_step(g0, p0, 32'd1);
        pp_r[0] <= p_step(p0, 32'd1);
        p_r[0]  <= p0;
        c_r[0]  <= c0;
        sa_r[0] <= a[WIDTH-1];
        sb_r[0] <= b_eff[WIDTH-1];
        for (int k = 1; k < LEVELS; k++) begin
          g_r[k]  <= g_step(g_r[k-1], pp_r[k-1], 32'd1 << k);
          p_r[k]  <= p_r[k-1];
          c_r[k]  <= c_r[k-1];
          sa_r[k] <= sa_r[k-1];
          sb_r[k] <= sb_r[k-1];
        end
        for (int k = 1; k < LEVELS - 1; k++) begin
          pp_r[k] <= p_step(pp_r[k-1], 32'd1 << k);
        end
      end
    end

    assign gf  = g_r[LEVELS-1];
    assign pf  = p_r[LEVELS-1];
    assign cf  = c_r[LEVELS-1];
    assign saf = sa_r[LEVELS-1];
    assign sbf = sb_r[LEVELS-1];
    assign vf  = v_r[LEVELS-1];
  end else begin : g_comb
    logic [WIDTH-1:0] pp;

    // Whole prefix tree in one combinational pass
    always_comb begin
      gf = g0;
      pp = p0;
      for (int k = 0; k < LEVELS; k++) begin
        gf = g_step(gf, pp, 32'd1 << k);
        pp = p_step(pp, 32'd1 << k);
      end
    end

    assign pf  = p0;
    assign cf  = c0;
    assign saf = a[WIDTH-1];
    assign sbf = b_eff[WIDTH-1];
    assign vf  = in_valid;
  end

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_c;
  logic             ovf_c;

  // Sum bits from prefix carries and signed overflow from operand/result signs
  always_comb begin
    carry = {gf[WIDTH-2:0], cf};
    sum_c = pf ^ carry;
    ovf_c = (saf == sbf) && (sum_c[WIDTH-1] != saf);
  end

  // Output register; holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= vf;
      sum       <= sum_c;
      cout      <= gf[WIDTH-1];
      ovf       <= ovf_c;
    end
  end

endmodule

// File: tb/tb_kogge_stone_pipe_adder.sv
// Scoreboard bench: a 16-bit pipelined instance and a 4-bit combinational instance,
// each with its own monitor comparing against an arithmetic reference model.
module tb_kogge_stone_pipe_adder;

  localparam int LAT16 = 5;
  localparam int LAT4  = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv16, ir16, cin16, sub16, ov16, or16, co16, of16;
  logic [15:0] a16, b16, s16;
  logic        iv4, ir4, cin4, sub4, ov4, or4, co4, of4;
  logic [3:0]  a4, b4, s4;

  kogge_stone_pipe_adder #(.WIDTH(16), .PIPE(1)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16),
    .cout(co16), .ovf(of16));

  kogge_stone_pipe_adder #(.WIDTH(4), .PIPE(0)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(cin4), .sub(sub4), .out_valid(ov4), .out_ready(or4), .sum(s4),
    .cout(co4), .ovf(of4));

  typedef struct {
    logic [65:0] exp;
    int          acc;
    bit          strict;
  } item_t;

  item_t q16[$];
  item_t q4[$];
  item_t it16, it4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit strict_mode = 1'b0;
  bit rnd_ready = 1'b0;
  bit hold_ready = 1'b1;
  int stall_cnt = 0;

  always @(posedge clk) cyc++;

  function automatic logic [65:0] mk(input bit c, input bit o, input logic [63:0] s);
    return {c, o, s};
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic logic [65:0] model(input int w, input longint unsigned av,
                                        input longint unsigned bv, input bit ci, input bit sb);
    longint unsigned m, half, u;
    longint sa, sv, t;
    bit c, o;
    m    = (64'd1 << w) - 64'd1;
    half = 64'd1 << (w - 1);
    sa   = (av >= half) ? longint'(av) - longint'(m) - 64'sd1 : longint'(av);
    sv   = (bv >= half) ? longint'(bv) - longint'(m) - 64'sd1 : longint'(bv);
    if (sb) begin
      u = av - bv;
      t = sa - sv;
      c = (av >= bv);
    end else begin
      u = av + bv + 64'(ci);
      t = sa + sv + 64'(ci);
      c = (u > m);
    end
    o = (t >= longint'(half)) || (t < -longint'(half));
    return {c, o, u & m};
  endfunction

  function automatic void chk(input string name, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor for the 16-bit pipelined instance
  logic [65:0] held16;
  bit          stall16 = 1'b0;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      stall16 = 1'b0;
    end else begin
      chk("in_ready16", 66'(ir16), 66'(!ov16 || or16));
      if (stall16) begin
        chk("hold_valid16", 66'(ov16), 66'(1));
        chk("hold_data16", mk(co16, of16, 64'(s16)), held16);
      end
      if (ov16 && or16) begin
        if (q16.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected16: got %h with nothing outstanding", s16);
        end else begin
          it16 = q16.pop_front();
          chk("result16", mk(co16, of16, 64'(s16)), it16.exp);
          if (it16.strict) chk("latency16", 66'(cyc - it16.acc), 66'(LAT16));
          else chk("min_latency16", 66'(cyc - it16.acc >= LAT16), 66'(1));
        end
      end
      stall16 = ov16 && !or16;
      held16  = mk(co16, of16, 64'(s16));
    end
  end

  // Monitor for the 4-bit combinational instance
  logic [65:0] held4;
  bit          stall4 = 1'b0;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      stall4 = 1'b0;
    end else begin
      chk("in_ready4", 66'(ir4), 66'(!ov4 || or4));
      if (stall4) begin
        chk("hold_valid4", 66'(ov4), 66'(1));
        chk("hold_data4", mk(co4, of4, 64'(s4)), held4);
      end
      if (ov4 && or4) begin
        if (q4.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected4: got %h with nothing outstanding", s4);
        end else begin
          it4 = q4.pop_front();
          chk("result4", mk(co4, of4, 64'(s4)), it4.exp);
          if (it4.strict) chk("latency4", 66'(cyc - it4.acc), 66'(LAT4));
          else chk("min_latency4", 66'(cyc - it4.acc >= LAT4), 66'(1));
        end
      end
      stall4 = ov4 && !or4;
      held4  = mk(co4, of4, 64'(s4));
    end
  end

  task automatic drive_ready(input bit d16);
    bit r;
    if (stall_cnt > 0) begin
      r = 1'b0;
      stall_cnt--;
    end else if (rnd_ready) begin
      r = ($urandom_range(0, 3) != 0);
    end else begin
      r = hold_ready;
    end
    if (d16) or16 = r;
    else or4 = r;
  endtask

  task automatic send(input bit d16, input logic [15:0] av, input logic [15:0] bv,
                      input bit ci, input bit sb, input logic [65:0] exp);
    item_t it;
    int    w;
    bit    done;
    w = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (d16) begin
        a16 = av; b16 = bv; cin16 = ci; sub16 = sb; iv16 = 1'b1;
      end else begin
        a4 = av[3:0]; b4 = bv[3:0]; cin4 = ci; sub4 = sb; iv4 = 1'b1;
      end
      drive_ready(d16);
      #1;
      if (d16 ? ir16 : ir4) begin
        it.exp = exp;
        it.acc = cyc;
        it.strict = strict_mode;
        if (d16) q16.push_back(it);
        else q4.push_back(it);
        done = 1'b1;
      end else begin
        w++;
        if (w > 200) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", w);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input bit d16, input int n);
    repeat (n) begin
      @(negedge clk);
      if (d16) iv16 = 1'b0;
      else iv4 = 1'b0;
      drive_ready(d16);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    @(negedge clk);
    iv16 = 1'b0; iv4 = 1'b0; or16 = 1'b1; or4 = 1'b1;
    rnd_ready = 1'b0; hold_ready = 1'b1; stall_cnt = 0;
    while ((q16.size() != 0 || q4.size() != 0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    chk("drain_outstanding", 66'(q16.size() + q4.size()), 66'(0));
  endtask

  logic [15:0] av, bv;
  bit          ci, sb;

  initial begin
    rst_n = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; or16 = 1'b1;
    iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0; or4 = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_out_valid16", 66'(ov16), 66'(0));
    chk("reset_data16", mk(co16, of16, 64'(s16)), 66'(0));
    chk("reset_out_valid4", 66'(ov4), 66'(0));
    chk("reset_data4", mk(co4, of4, 64'(s4)), 66'(0));
    chk("reset_in_ready16", 66'(ir16), 66'(1));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Directed 4-bit combinational cases, back-to-back
    strict_mode = 1'b1; rnd_ready = 1'b0; hold_ready = 1'b1;
    send(1'b0, 16'hD, 16'h3, 1'b0, 1'b0, mk(1'b1, 1'b0, 64'h0));
    send(1'b0, 16'hA, 16'h6, 1'b0, 1'b0, mk(1'b1, 1'b0, 64'h0));
    send(1'b0, 16'hB, 16'h7, 1'b0, 1'b0, mk(1'b1, 1'b0, 64'h2));
    send(1'b0, 16'h3, 16'h5, 1'b1, 1'b1, mk(1'b0, 1'b0, 64'hE));
    send(1'b0, 16'h7, 16'h1, 1'b0, 1'b0, mk(1'b0, 1'b1, 64'h8));
    drain();

    // Directed 16-bit pipelined cases: overflow, wrap, subtract with ignored cin
    strict_mode = 1'b1;
    send(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(1'b0, 1'b1, 64'h8000));
    send(1'b1, 16'hFFFF, 16'h0001, 1'b1, 1'b0, mk(1'b1, 1'b0, 64'h0001));
    send(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, mk(1'b0, 1'b0, 64'hFFFE));
    send(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b1, mk(1'b1, 1'b1, 64'h7FFF));
    drain();

    // Back-pressure: fill the pipe with the consumer stalled
    strict_mode = 1'b0; rnd_ready = 1'b0; hold_ready = 1'b0;
    repeat (5) begin
      av = pick16(); bv = pick16(); ci = 1'($urandom); sb = 1'($urandom);
      send(1'b1, av, bv, ci, sb, model(16, 64'(av), 64'(bv), ci, sb));
    end
    @(negedge clk);
    iv16 = 1'b0; or16 = 1'b0;
    #1;
    chk("bp_in_ready", 66'(ir16), 66'(0));
    chk("bp_out_valid", 66'(ov16), 66'(1));
    stall_cnt = 3; hold_ready = 1'b1;
    av = pick16(); bv = pick16(); ci = 1'($urandom); sb = 1'($urandom);
    send(1'b1, av, bv, ci, sb, model(16, 64'(av), 64'(bv), ci, sb));
    drain();

    // Asynchronous reset with operands in flight
    strict_mode = 1'b1;
    repeat (3) begin
      av = pick16(); bv = pick16(); ci = 1'($urandom); sb = 1'($urandom);
      send(1'b1, av, bv, ci, sb, model(16, 64'(av), 64'(bv), ci, sb));
    end
    @(negedge clk);
    iv16 = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 66'(ov16), 66'(0));
    chk("midreset_sum", 66'(s16), 66'(0));
    q16.delete();
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    idle(1'b1, 8);
    send(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, mk(1'b0, 1'b0, 64'h5556));
    drain();

    // Randomised 4-bit combinational traffic
    strict_mode = 1'b0; rnd_ready = 1'b1;
    repeat (3000) begin
      av = 16'($urandom_range(0, 15)); bv = 16'($urandom_range(0, 15));
      ci = 1'($urandom); sb = 1'($urandom);
      send(1'b0, av, bv, ci, sb, model(4, 64'(av), 64'(bv), ci, sb));
      if ($urandom_range(0, 4) == 0) idle(1'b0, $urandom_range(1, 3));
    end
    drain();

    // Randomised 16-bit pipelined traffic
    strict_mode = 1'b0; rnd_ready = 1'b1;
    repeat (4000) begin
      av = pick16(); bv = pick16(); ci = 1'($urandom); sb = 1'($urandom);
      send(1'b1, av, bv, ci, sb, model(16, 64'(av), 64'(bv), ci, sb));
      if ($urandom_range(0, 4) == 0) idle(1'b1, $urandom_range(1, 3));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
